// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared state encoding and helpers for the calculator sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } seq_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module : calc_cycle_counter
// Brief  : Saturating up-counter with sync clear and terminal-count compare.
// Rev    : 1.0 - initial release
// ============================================================================
module calc_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : calc_sequencer
// Brief  : LOAD -> EXEC -> WRITE -> DONE control sequencer for the calc datapath.
// Rev    : 1.0 - initial release
// ============================================================================
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_OPERANDS   = 2,
  parameter int EXEC_CYCLES    = 1,
  parameter int WAIT_READY     = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    ack_i,
  input  logic                    exec_ready_i,
  output logic [NUM_OPERANDS-1:0] op_we_o,
  output logic                    fct_we_o,
  output logic                    s_we_o,
  output logic                    flag_we_o,
  output logic                    clr_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [STATE_W-1:0]      state_o
);

  localparam int c_cnt_w = $clog2(max_of(EXEC_CYCLES, TIMEOUT_CYCLES) + 1);
  // The counter reads n-1 during the n-th EXEC cycle, so the last cycle is limit-1.
  localparam int c_term  = (WAIT_READY != 0) ? TIMEOUT_CYCLES - 1 : EXEC_CYCLES - 1;
  localparam logic [c_cnt_w-1:0] c_term_v = c_cnt_w'(c_term);

  if (NUM_OPERANDS < 1) begin : g_chk_num_operands
    $error("calc_sequencer: NUM_OPERANDS must be >= 1");
  end
  if (EXEC_CYCLES < 1) begin : g_chk_exec_cycles
    $error("calc_sequencer: EXEC_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout_cycles
    $error("calc_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_t r_state;
  seq_state_t w_next;
  logic       r_timeout;
  logic       w_tc;
  logic       w_set_to;

  calc_cycle_counter #(
    .WIDTH (c_cnt_w)
  ) u_cnt (
    .clk    (clock_i),
    .rst    (reset_i),
    .i_clr  (r_state != ST_EXEC),
    .i_en   (r_state == ST_EXEC),
    .i_term (c_term_v),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_to) begin
        r_timeout <= 1'b1;
      end else if (r_state != ST_DONE) begin
        r_timeout <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = start_i ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_next = ST_EXEC;
      ST_EXEC: begin
        if (WAIT_READY == 0) begin
          w_next = w_tc ? ST_WRITE : ST_EXEC;
        end else if (exec_ready_i) begin
          w_next = ST_WRITE;
        end else begin
          w_next = w_tc ? ST_DONE : ST_EXEC;
        end
      end
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ack_i ? ST_IDLE : ST_DONE;
      ST_ABORT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (abort_i && ((r_state == ST_LOAD) || (r_state == ST_EXEC) ||
                    (r_state == ST_WRITE) || (r_state == ST_DONE))) begin
      w_next = ST_ABORT;
    end
  end

  // Only a timed-out EXEC goes straight to DONE; WRITE always precedes a normal DONE.
  assign w_set_to = (r_state == ST_EXEC) && (w_next == ST_DONE);

  always_comb begin
    op_we_o   = '0;
    fct_we_o  = 1'b0;
    s_we_o    = 1'b0;
    flag_we_o = 1'b0;
    clr_o     = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    state_o   = r_state;
    case (r_state)
      ST_LOAD: begin
        op_we_o  = {NUM_OPERANDS{1'b1}};
        fct_we_o = 1'b1;
        busy_o   = 1'b1;
      end
      ST_EXEC:  busy_o = 1'b1;
      ST_WRITE: begin
        s_we_o    = 1'b1;
        flag_we_o = 1'b1;
        busy_o    = 1'b1;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        timeout_o = r_timeout;
      end
      ST_ABORT: clr_o = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
